// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: sequencer state encoding and instruction-word field positions.
package hack_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned IR_CBIT = 15;
  localparam int unsigned DEST_A  = 5;
  localparam int unsigned DEST_D  = 4;
  localparam int unsigned DEST_M  = 3;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FAULT = 2'd2,
    ST_STEP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/hack_dest_decode.sv
// Combinational Hack instruction decode: A/C instruction type and destination bits.
module hack_dest_decode
  import hack_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  output logic               o_is_c,
  output logic               o_dest_a,
  output logic               o_dest_d,
  output logic               o_dest_m
);

  logic w_unused_bits;

  assign o_is_c   = i_ir[IR_CBIT];
  assign o_dest_a = i_ir[DEST_A];
  assign o_dest_d = i_ir[DEST_D];
  assign o_dest_m = i_ir[DEST_M];

  // Computation and jump fields are consumed by the datapath, not here.
  assign w_unused_bits = ^{i_ir[14:6], i_ir[2:0]};

endmodule

// File: rtl/hack_fetch_sequencer.sv
// Hack fetch/execute sequencer: ROM handshake, IR load, PC, one-cycle A/D/M write strobes.
// Optional HACK_SINGLE_STEP_EN adds step/step_mode ports and the STEP hold state.
module hack_fetch_sequencer
  import hack_pkg::*;
#(
  parameter int unsigned PC_W     = 15,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
`ifdef HACK_SINGLE_STEP_EN
  input  logic               step,
  input  logic               step_mode,
`endif
  output logic [PC_W-1:0]    rom_addr,
  output logic               rom_req,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               ir_load,
  input  logic [INSTR_W-1:0] ir_q,
  input  logic               mem_wait,
  input  logic               jump_taken,
  input  logic [INSTR_W-1:0] jump_target,
  output logic               a_load,
  output logic               d_load,
  output logic               m_write,
  output logic [PC_W-1:0]    pc,
  output logic [1:0]         state,
  output logic               timeout_err
);

  localparam int unsigned     WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  seq_state_t        r_state, w_next;
  logic [PC_W-1:0]   r_pc, w_pc_next;
  logic [WAIT_W-1:0] r_wait, w_wait_next;
  logic              r_err, w_err_next;
  logic              w_is_c, w_dest_a, w_dest_d, w_dest_m;
  logic              w_rom_req, w_ir_load, w_a_load, w_d_load, w_m_write;
  seq_state_t        w_done_state;
  logic              w_unused_in;

  hack_dest_decode u_dest_decode (
    .i_ir     (ir_q),
    .o_is_c   (w_is_c),
    .o_dest_a (w_dest_a),
    .o_dest_d (w_dest_d),
    .o_dest_m (w_dest_m)
  );

`ifdef HACK_SINGLE_STEP_EN
  assign w_done_state = step_mode ? ST_STEP : ST_FETCH;
`else
  assign w_done_state = ST_FETCH;
`endif

  always_comb begin
    w_next      = r_state;
    w_pc_next   = r_pc;
    w_wait_next = r_wait;
    w_err_next  = r_err;
    w_rom_req   = 1'b0;
    w_ir_load   = 1'b0;
    w_a_load    = 1'b0;
    w_d_load    = 1'b0;
    w_m_write   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_rom_req = 1'b1;
        if (rom_ack) begin
          w_ir_load   = 1'b1;
          w_wait_next = '0;
          w_next      = ST_EXEC;
        end else if (r_wait == WAIT_W'(WAIT_MAX)) begin
          w_err_next = 1'b1;
          w_next     = ST_FAULT;
        end else begin
          w_wait_next = r_wait + WAIT_W'(1);
        end
      end
      ST_EXEC: begin
        if (!w_is_c) begin
          w_a_load  = 1'b1;
          w_pc_next = r_pc + PC_W'(1);
          w_next    = w_done_state;
        end else if (!mem_wait) begin
          w_a_load  = w_dest_a;
          w_d_load  = w_dest_d;
          w_m_write = w_dest_m;
          w_pc_next = jump_taken ? jump_target[PC_W-1:0] : r_pc + PC_W'(1);
          w_next    = w_done_state;
        end
      end
      ST_FAULT: w_next = ST_FAULT;
`ifdef HACK_SINGLE_STEP_EN
      ST_STEP: begin
        if (step) w_next = ST_FETCH;
      end
`endif
      default: w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= PC_RST;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_wait  <= w_wait_next;
      r_err   <= w_err_next;
    end
  end

  // Reset is synchronous, so outputs are masked directly to be quiet during the reset cycle itself.
  assign rom_req     = w_rom_req & ~reset;
  assign ir_load     = w_ir_load & ~reset;
  assign a_load      = w_a_load  & ~reset;
  assign d_load      = w_d_load  & ~reset;
  assign m_write     = w_m_write & ~reset;
  assign pc          = reset ? PC_RST : r_pc;
  assign rom_addr    = pc;
  assign state       = reset ? ST_FETCH : r_state;
  assign timeout_err = r_err & ~reset;

  // rom_data feeds the external IR directly; jump_target bits above PC_W are ignored.
  assign w_unused_in = ^{rom_data, jump_target};

endmodule

// File: tb/tb_hack_fetch_sequencer.sv
// Self-checking bench for hack_fetch_sequencer: directed vector table, corner sequences, randomized model check.
module tb_hack_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        ir_load;
  logic [15:0] ir_q;
  logic        mem_wait;
  logic        jump_taken;
  logic [15:0] jump_target;
  logic        a_load, d_load, m_write;
  logic [14:0] pc;
  logic [1:0]  state;
  logic        timeout_err;
`ifdef HACK_SINGLE_STEP_EN
  logic        step;
  logic        step_mode;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hack_fetch_sequencer #(
    .PC_W     (15),
    .RESET_PC (0),
    .WAIT_MAX (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef HACK_SINGLE_STEP_EN
    .step        (step),
    .step_mode   (step_mode),
`endif
    .rom_addr    (rom_addr),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .ir_load     (ir_load),
    .ir_q        (ir_q),
    .mem_wait    (mem_wait),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .a_load      (a_load),
    .d_load      (d_load),
    .m_write     (m_write),
    .pc          (pc),
    .state       (state),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic        rst, ack, mw, jt;
    logic [15:0] jtgt, rd;
    logic        e_req, e_irl, e_a, e_d, e_m;
    logic [14:0] e_pc;
    logic [1:0]  e_st;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, ack, mw, jt, input logic [15:0] jtgt, rd,
                              input logic e_req, e_irl, e_a, e_d, e_m,
                              input logic [14:0] e_pc, input logic [1:0] e_st, input logic e_err);
    vec_t v;
    v.rst = rst; v.ack = ack; v.mw = mw; v.jt = jt; v.jtgt = jtgt; v.rd = rd;
    v.e_req = e_req; v.e_irl = e_irl; v.e_a = e_a; v.e_d = e_d; v.e_m = e_m;
    v.e_pc = e_pc; v.e_st = e_st; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic e_req, e_irl, e_a, e_d, e_m,
                             input logic [14:0] e_pc, input logic [1:0] e_st, input logic e_err);
    chk({tag, " rom_req"}, 32'(rom_req), 32'(e_req));
    chk({tag, " ir_load"}, 32'(ir_load), 32'(e_irl));
    chk({tag, " a/d/m"}, 32'({a_load, d_load, m_write}), 32'({e_a, e_d, e_m}));
    chk({tag, " pc"}, 32'(pc), 32'(e_pc));
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'(e_pc));
    chk({tag, " state"}, 32'(state), 32'(e_st));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'(e_err));
  endtask

  task automatic drive(input logic rst, ack, mw, jt, input logic [15:0] jtgt, rd);
    reset = rst; rom_ack = ack; mem_wait = mw; jump_taken = jt;
    jump_target = jtgt; rom_data = rd;
    #2;
  endtask

  // External IR register: captures rom_data whenever the sequencer pulses ir_load.
  task automatic tick();
    logic        ld;
    logic [15:0] d;
    ld = ir_load;
    d  = rom_data;
    @(posedge clk);
    #1;
    if (ld) ir_q = d;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 16'h0, 16'h0);
    expect_outs("reset", 0, 0, 0, 0, 0, 15'h0, 2'd0, 0);
    tick();
  endtask

  int          m_st, m_pc, m_miss;
  logic        m_err;
  logic [15:0] m_ir;

  initial begin
    logic        rst, ack, mw, jt;
    logic [15:0] jtgt, rd;
    logic        e_req, e_irl, e_a, e_d, e_m;
`ifdef HACK_SINGLE_STEP_EN
    step = 0; step_mode = 0;
`endif
    ir_q = 16'h0;
    reset = 1; rom_ack = 0; mem_wait = 0; jump_taken = 0; jump_target = 0; rom_data = 0;
    @(posedge clk);
    #1;

    // rst ack mw jt jtgt rd | req irl a d m pc st err
    tbl.push_back(mk(1,0,0,0,16'h0000,16'h0000, 0,0,0,0,0, 15'h000,2'd0,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,16'h0005, 1,1,0,0,0, 15'h000,2'd0,0));
    tbl.push_back(mk(0,0,1,0,16'h0000,16'h0000, 0,0,1,0,0, 15'h000,2'd1,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,16'hE038, 1,1,0,0,0, 15'h001,2'd0,0));
    tbl.push_back(mk(0,0,1,0,16'h0000,16'h0000, 0,0,0,0,0, 15'h001,2'd1,0));
    tbl.push_back(mk(0,0,1,0,16'h0000,16'h0000, 0,0,0,0,0, 15'h001,2'd1,0));
    tbl.push_back(mk(0,0,1,0,16'h0000,16'h0000, 0,0,0,0,0, 15'h001,2'd1,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,16'h0000, 0,0,1,1,1, 15'h001,2'd1,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,16'hE307, 1,1,0,0,0, 15'h002,2'd0,0));
    tbl.push_back(mk(0,0,0,1,16'h0123,16'h0000, 0,0,0,0,0, 15'h002,2'd1,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,16'h0000, 1,0,0,0,0, 15'h123,2'd0,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,16'h0042, 1,1,0,0,0, 15'h123,2'd0,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,16'h0000, 0,0,1,0,0, 15'h123,2'd1,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,16'hE010, 1,1,0,0,0, 15'h124,2'd0,0));
    tbl.push_back(mk(0,0,1,0,16'h0000,16'h0000, 0,0,0,0,0, 15'h124,2'd1,0));
    tbl.push_back(mk(1,0,1,0,16'h0000,16'h0000, 0,0,0,0,0, 15'h000,2'd0,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,16'h0000, 1,0,0,0,0, 15'h000,2'd0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].mw, tbl[i].jt, tbl[i].jtgt, tbl[i].rd);
      expect_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_irl, tbl[i].e_a,
                  tbl[i].e_d, tbl[i].e_m, tbl[i].e_pc, tbl[i].e_st, tbl[i].e_err);
      tick();
    end

    // ROM never answers: 16 waiting cycles, then sticky fault until reset.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 0, 0, 16'h0, 16'h0);
      expect_outs($sformatf("tmo wait%0d", k), 1, 0, 0, 0, 0, 15'h0, 2'd0, 0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 16'h0, 16'h0001);
      expect_outs($sformatf("fault%0d", k), 0, 0, 0, 0, 0, 15'h0, 2'd2, 1);
      tick();
    end
    do_reset();
    drive(0, 0, 0, 0, 16'h0, 16'h0);
    expect_outs("post-fault", 1, 0, 0, 0, 0, 15'h0, 2'd0, 0);
    tick();

    // Jump to 0x7FFF (upper target bit ignored), ack on last tolerated wait, A-instr wraps pc.
    do_reset();
    drive(0, 1, 0, 0, 16'h0, 16'hE007);
    expect_outs("wrap fetch", 1, 1, 0, 0, 0, 15'h0, 2'd0, 0);
    tick();
    drive(0, 0, 0, 1, 16'hFFFF, 16'h0);
    expect_outs("wrap jump", 0, 0, 0, 0, 0, 15'h0, 2'd1, 0);
    tick();
    for (int k = 0; k < 15; k++) begin
      drive(0, 0, 0, 0, 16'h0, 16'h0);
      expect_outs($sformatf("late wait%0d", k), 1, 0, 0, 0, 0, 15'h7FFF, 2'd0, 0);
      tick();
    end
    drive(0, 1, 0, 0, 16'h0, 16'h0001);
    expect_outs("late ack", 1, 1, 0, 0, 0, 15'h7FFF, 2'd0, 0);
    tick();
    drive(0, 0, 0, 0, 16'h0, 16'h0);
    expect_outs("wrap exec", 0, 0, 1, 0, 0, 15'h7FFF, 2'd1, 0);
    tick();
    drive(0, 0, 0, 0, 16'h0, 16'h0);
    expect_outs("wrapped", 1, 0, 0, 0, 0, 15'h0, 2'd0, 0);
    tick();

`ifdef HACK_SINGLE_STEP_EN
    do_reset();
    step_mode = 1;
    drive(0, 1, 0, 0, 16'h0, 16'h0001);
    expect_outs("step fetch", 1, 1, 0, 0, 0, 15'h0, 2'd0, 0);
    tick();
    step = 1;
    drive(0, 0, 0, 0, 16'h0, 16'h0);
    expect_outs("step exec", 0, 0, 1, 0, 0, 15'h0, 2'd1, 0);
    tick();
    step = 0;
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 0, 16'h0, 16'h0);
      expect_outs($sformatf("step hold%0d", k), 0, 0, 0, 0, 0, 15'h1, 2'd3, 0);
      tick();
    end
    step = 1;
    drive(0, 0, 0, 0, 16'h0, 16'h0);
    expect_outs("step pulse", 0, 0, 0, 0, 0, 15'h1, 2'd3, 0);
    tick();
    step = 0;
    step_mode = 0;
    drive(0, 0, 0, 0, 16'h0, 16'h0);
    expect_outs("step resumed", 1, 0, 0, 0, 0, 15'h1, 2'd0, 0);
    tick();
`endif

    // Randomized run against a cycle model built from the behavioural rules.
    m_st = 0; m_pc = 0; m_miss = 0; m_err = 0; m_ir = 16'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst  = (cyc == 0) || ($urandom_range(0, 99) < 2);
      ack  = $urandom_range(0, 99) < 75;
      mw   = $urandom_range(0, 99) < 40;
      jt   = 1'($urandom_range(0, 1));
      jtgt = 16'($urandom);
      rd   = 16'($urandom);
      e_req = 0; e_irl = 0; e_a = 0; e_d = 0; e_m = 0;
      if (!rst) begin
        if (m_st == 0) begin
          e_req = 1;
          e_irl = ack;
        end else if (m_st == 1) begin
          if (!m_ir[15]) e_a = 1;
          else if (!mw) {e_a, e_d, e_m} = m_ir[5:3];
        end
      end
      drive(rst, ack, mw, jt, jtgt, rd);
      expect_outs($sformatf("rand%0d", cyc), e_req, e_irl, e_a, e_d, e_m,
                  rst ? 15'h0 : 15'(m_pc), rst ? 2'd0 : 2'(m_st), rst ? 1'b0 : m_err);
      if (rst) begin
        m_st = 0; m_pc = 0; m_miss = 0; m_err = 0;
      end else if (m_st == 0) begin
        if (ack) begin
          m_ir = rd; m_miss = 0; m_st = 1;
        end else begin
          m_miss = m_miss + 1;
          if (m_miss > 15) begin
            m_st = 2; m_err = 1;
          end
        end
      end else if (m_st == 1) begin
        if (!m_ir[15]) begin
          m_pc = (m_pc + 1) % 32768; m_st = 0;
        end else if (!mw) begin
          m_pc = jt ? int'(jtgt) % 32768 : (m_pc + 1) % 32768;
          m_st = 0;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
